// File: rtl/memory_unit.sv
// memory_unit: word-addressed 32-bit RAM behind the MAR/MDR pair, with a
// wait-state handshake (IDLE -> WAIT -> DONE) for the control sequencer.
// Optional build macro: ADDR_CHECK_EN (reject addresses beyond the array).
// Ports:
//   clock    in   rising-edge system clock
//   clear    in   asynchronous active-low reset
//   Read     in   read strobe, access starts on its rising edge
//   Write    in   write strobe, access starts on its rising edge
//   address  in   word address from MAR (low ADDR_BITS bits index the array)
//   data_in  in   write data from MDR
//   Mdatain  out  read data, held until the next read completes
//   busy     out  high while an access is in WAIT or DONE
//   done     out  one-cycle completion pulse
//   err      out  one-cycle error flag, only with done
module memory_unit #(
    parameter int ADDR_BITS   = 9,
    parameter int WAIT_STATES = 2
) (
    input  logic        clock,
    input  logic        clear,
    input  logic        Read,
    input  logic        Write,
    input  logic [31:0] address,
    input  logic [31:0] data_in,
    output logic [31:0] Mdatain,
    output logic        busy,
    output logic        done,
    output logic        err
);

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        DONE
    } state_t;

    state_t state;
    state_t state_nx;

    logic                 read_q;
    logic                 write_q;
    logic [3:0]           count;
    logic                 op_rd;
    logic                 op_wr;
    logic                 op_bad;
    logic [ADDR_BITS-1:0] idx;
    logic [31:0]          wdata;
    logic [31:0]          mem [2**ADDR_BITS];

    logic rd_rise;
    logic wr_rise;
    logic start;
    logic finish;
    logic addr_bad;

    assign rd_rise = Read & ~read_q;
    assign wr_rise = Write & ~write_q;
    assign start   = (state == IDLE) & (rd_rise | wr_rise);
    assign finish  = (state == WAIT) & (count == 4'd0);
    assign busy    = (state != IDLE);

`ifdef ADDR_CHECK_EN
    assign addr_bad = |address[31:ADDR_BITS];
`else
    // Upper bits are ignored so the array wraps modulo its depth.
    logic unused_hi;
    assign unused_hi = ^address[31:ADDR_BITS];
    assign addr_bad  = 1'b0;
`endif

    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    if (start) state_nx = WAIT;
            WAIT:    if (count == 4'd0) state_nx = DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            read_q  <= 1'b0;
            write_q <= 1'b0;
            count   <= 4'd0;
            op_rd   <= 1'b0;
            op_wr   <= 1'b0;
            op_bad  <= 1'b0;
            idx     <= '0;
            wdata   <= 32'd0;
            Mdatain <= 32'd0;
            done    <= 1'b0;
            err     <= 1'b0;
        end else begin
            read_q  <= Read;
            write_q <= Write;
            done    <= finish;
            err     <= finish & op_bad;
            if (start) begin
                op_rd  <= rd_rise;
                op_wr  <= wr_rise;
                // Simultaneous strobes are ambiguous: run the handshake, touch nothing.
                op_bad <= (rd_rise & wr_rise) | addr_bad;
                idx    <= address[ADDR_BITS-1:0];
                wdata  <= data_in;
                count  <= 4'(WAIT_STATES);
            end else if (state == WAIT && count != 4'd0) begin
                count <= count - 4'd1;
            end
            if (finish & op_rd & ~op_bad) begin
                Mdatain <= mem[idx];
            end
        end
    end

    // Commit happens only on the WAIT->DONE edge; a reset in WAIT forces
    // IDLE first, so an interrupted write never lands.
    always_ff @(posedge clock) begin
        if (finish & op_wr & ~op_bad) begin
            mem[idx] <= wdata;
        end
    end

endmodule

// File: tb/tb_memory_unit.sv
// tb_memory_unit: directed test of memory_unit with two instances sharing
// stimulus (WAIT_STATES=2 and WAIT_STATES=0) against a timeline model.
module tb_memory_unit;

    logic        clock   = 1'b0;
    logic        clear   = 1'b1;
    logic        Read    = 1'b0;
    logic        Write   = 1'b0;
    logic [31:0] address = 32'd0;
    logic [31:0] data_in = 32'd0;

    logic [31:0] md0;
    logic        busy0;
    logic        done0;
    logic        err0;
    logic [31:0] md1;
    logic        busy1;
    logic        done1;
    logic        err1;

    int n_tot = 0;
    int n_bad = 0;
    int dcnt0 = 0;
    int dcnt1 = 0;

    always #5 clock = ~clock;

    memory_unit #(.ADDR_BITS(9), .WAIT_STATES(2)) u0 (
        .clock(clock), .clear(clear), .Read(Read), .Write(Write),
        .address(address), .data_in(data_in),
        .Mdatain(md0), .busy(busy0), .done(done0), .err(err0)
    );

    memory_unit #(.ADDR_BITS(9), .WAIT_STATES(0)) u1 (
        .clock(clock), .clear(clear), .Read(Read), .Write(Write),
        .address(address), .data_in(data_in),
        .Mdatain(md1), .busy(busy1), .done(done1), .err(err1)
    );

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_tot++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    // Timeline model: an access accepted at edge st is busy through edge
    // st+WS+1 (the DONE cycle), where done/err pulse and effects apply.
    int          k = 0;
    bit          pend  [2] = '{0, 0};
    int          st    [2];
    int          fn    [2];
    bit          m_rd  [2];
    bit          m_wr  [2];
    bit          m_bad [2];
    logic [8:0]  m_idx [2];
    logic [31:0] m_dat [2];
    logic [31:0] m_mem [2][512];
    logic [31:0] e_md  [2] = '{32'd0, 32'd0};
    bit          e_busy[2] = '{0, 0};
    bit          e_done[2] = '{0, 0};
    bit          e_err [2] = '{0, 0};
    bit          pr = 0;
    bit          pw = 0;
    bit          rr;
    bit          wr;
    bit          was_busy;
    bit          a_bad;

    function automatic int ws(input int i);
        return (i == 0) ? 2 : 0;
    endfunction

    always @(posedge clock or negedge clear) begin
        if (!clear) begin
            for (int i = 0; i < 2; i++) begin
                pend[i]   = 0;
                e_md[i]   = 32'd0;
                e_busy[i] = 0;
                e_done[i] = 0;
                e_err[i]  = 0;
            end
            pr = 0;
            pw = 0;
        end else begin
            rr = Read && !pr;
            wr = Write && !pw;
`ifdef ADDR_CHECK_EN
            a_bad = (address[31:9] != 23'd0);
`else
            a_bad = 0;
`endif
            for (int i = 0; i < 2; i++) begin
                was_busy  = pend[i] && (k - 1) <= fn[i];
                e_done[i] = 0;
                e_err[i]  = 0;
                if (!was_busy && (rr || wr)) begin
                    pend[i]  = 1;
                    st[i]    = k;
                    fn[i]    = k + ws(i) + 1;
                    m_rd[i]  = rr;
                    m_wr[i]  = wr;
                    m_bad[i] = (rr && wr) || a_bad;
                    m_idx[i] = address[8:0];
                    m_dat[i] = data_in;
                end
                if (pend[i] && k == fn[i]) begin
                    e_done[i] = 1;
                    e_err[i]  = m_bad[i];
                    if (!m_bad[i] && m_wr[i]) m_mem[i][m_idx[i]] = m_dat[i];
                    if (!m_bad[i] && m_rd[i]) e_md[i] = m_mem[i][m_idx[i]];
                end
                e_busy[i] = pend[i] && k >= st[i] && k <= fn[i];
            end
            pr = Read;
            pw = Write;
            k++;
        end
    end

    always @(negedge clock) begin
        chk("md0",   md0,          e_md[0]);
        chk("busy0", 32'(busy0),   32'(e_busy[0]));
        chk("done0", 32'(done0),   32'(e_done[0]));
        chk("err0",  32'(err0),    32'(e_err[0]));
        chk("md1",   md1,          e_md[1]);
        chk("busy1", 32'(busy1),   32'(e_busy[1]));
        chk("done1", 32'(done1),   32'(e_done[1]));
        chk("err1",  32'(err1),    32'(e_err[1]));
        if (done0) dcnt0++;
        if (done1) dcnt1++;
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clock);
        #1;
    endtask

    task automatic access(input logic rd, input logic wrt,
                          input logic [31:0] a, input logic [31:0] d);
        Read    = rd;
        Write   = wrt;
        address = a;
        data_in = d;
        cyc(1);
        Read  = 1'b0;
        Write = 1'b0;
        cyc(5);
    endtask

    // Strobes held 5 cycles; literal latency for the WAIT_STATES=2 instance.
    task automatic step_access(input string nm, input logic rd,
                               input logic wrt, input logic [31:0] a,
                               input logic [31:0] d, input logic exp_err);
        Read    = rd;
        Write   = wrt;
        address = a;
        data_in = d;
        for (int c = 0; c < 5; c++) begin
            cyc(1);
            chk({nm, "_busy"}, 32'(busy0), 32'(c <= 3));
            chk({nm, "_done"}, 32'(done0), 32'(c == 3));
            chk({nm, "_err"},  32'(err0),  32'(c == 3 && exp_err));
        end
        Read  = 1'b0;
        Write = 1'b0;
        cyc(4);
    endtask

    initial begin
        #1 clear = 1'b0;
        cyc(2);
        chk("rst_md0",   md0,        32'd0);
        chk("rst_busy0", 32'(busy0), 32'd0);
        chk("rst_done1", 32'(done1), 32'd0);
        clear = 1'b1;
        cyc(2);

        access(1'b0, 1'b1, 32'h10,  32'h000000A5);
        access(1'b0, 1'b1, 32'h30,  32'h00000011);
        access(1'b0, 1'b1, 32'h05,  32'h00000000);
        access(1'b0, 1'b1, 32'h20,  32'h00000007);

        step_access("t1", 1'b1, 1'b0, 32'h10, 32'h0, 1'b0);
        chk("t1_md0", md0, 32'h000000A5);
        chk("t1_md1", md1, 32'h000000A5);

        dcnt0   = 0;
        dcnt1   = 0;
        Read    = 1'b1;
        address = 32'h10;
        cyc(10);
        Read = 1'b0;
        cyc(5);
        chk("t2_pulses0", dcnt0, 1);
        chk("t2_pulses1", dcnt1, 1);
        chk("t2_md0", md0, 32'h000000A5);

        step_access("t3", 1'b1, 1'b1, 32'h30, 32'h99, 1'b1);
        access(1'b1, 1'b0, 32'h30, 32'h0);
        chk("t3_md0", md0, 32'h00000011);
        chk("t3_md1", md1, 32'h00000011);

`ifdef ADDR_CHECK_EN
        step_access("t4", 1'b0, 1'b1, 32'h205, 32'hDEADBEEF, 1'b1);
        access(1'b1, 1'b0, 32'h005, 32'h0);
        chk("t4_md0", md0, 32'h00000000);
`else
        step_access("t4", 1'b0, 1'b1, 32'h205, 32'hDEADBEEF, 1'b0);
        access(1'b1, 1'b0, 32'h005, 32'h0);
        chk("t4_md0", md0, 32'hDEADBEEF);
`endif

        access(1'b1, 1'b0, 32'h10, 32'h0);
        Write   = 1'b1;
        address = 32'h20;
        data_in = 32'h12345678;
        cyc(1);
        clear = 1'b0;
        Write = 1'b0;
        #1;
        chk("t5_md0",   md0,        32'd0);
        chk("t5_busy0", 32'(busy0), 32'd0);
        chk("t5_done0", 32'(done0), 32'd0);
        chk("t5_err0",  32'(err0),  32'd0);
        chk("t5_busy1", 32'(busy1), 32'd0);
        cyc(2);
        clear = 1'b1;
        cyc(2);
        access(1'b1, 1'b0, 32'h20, 32'h0);
        chk("t5_md0r", md0, 32'h00000007);
        chk("t5_md1r", md1, 32'h00000007);

        dcnt0   = 0;
        dcnt1   = 0;
        Read    = 1'b1;
        address = 32'h30;
        cyc(1);
        Read = 1'b0;
        cyc(1);
        chk("t6_done1", 32'(done1), 32'd1);
        Read = 1'b1;
        cyc(1);
        Read = 1'b0;
        cyc(6);
        chk("t6_pulses1", dcnt1, 1);
        chk("t6_pulses0", dcnt0, 1);
        chk("t6_md1", md1, 32'h00000011);

        $display("test done: total=%0d bad=%0d", n_tot, n_bad);
        $finish;
    end

endmodule
